// File: rtl/ahb_param_decoder.sv
// AHB input-stage decoder: combinational address-phase select, one registered data-phase owner, built-in ERROR default slave.
// Response mux follows the registered owner; the owner only advances when HREADYS is high, so stalls come straight from the selected port.
module ahb_param_decoder #(
   parameter int NUM_PORTS = 4,
   parameter int DATA_W    = 32,
   parameter int USER_W    = 32,
   parameter logic [NUM_PORTS*22-1:0] BASE = {22'h180000, 22'h100000, 22'h080000, 22'h000000},
   parameter logic [NUM_PORTS*22-1:0] MASK = {22'h3FFFFF, 22'h3C0000, 22'h3FFFC0, 22'h3FFFC0}
) (
   input  logic                        HCLK,
   input  logic                        HRESET,
   input  logic                        HREADYS,
   input  logic                        sel_dec,
   input  logic [21:0]                 decode_addr_dec,
   input  logic [1:0]                  trans_dec,
   input  logic [NUM_PORTS-1:0]        active_in,
   input  logic [NUM_PORTS-1:0]        readyout_in,
   input  logic [2*NUM_PORTS-1:0]      resp_in,
   input  logic [DATA_W*NUM_PORTS-1:0] rdata_in,
   input  logic [USER_W*NUM_PORTS-1:0] ruser_in,
   output logic [NUM_PORTS-1:0]        sel_out,
   output logic                        active_dec,
   output logic                        HREADYOUTS,
   output logic [1:0]                  HRESPS,
   output logic [DATA_W-1:0]           HRDATAS,
   output logic [USER_W-1:0]           HRUSERS,
   output logic [7:0]                  dft_err_cnt
);

   typedef enum logic [1:0] {
      D_IDLE = 2'd0,
      D_ERR1 = 2'd1,
      D_ERR2 = 2'd2
   } dft_state_t;

   localparam logic [NUM_PORTS:0] SEL_P0  = {{NUM_PORTS{1'b0}}, 1'b1};
   localparam logic [NUM_PORTS:0] SEL_DFT = {1'b1, {NUM_PORTS{1'b0}}};
   localparam logic [1:0]         RESP_OKAY  = 2'b00;
   localparam logic [1:0]         RESP_ERROR = 2'b01;

   logic [NUM_PORTS-1:0] hit;
   logic [NUM_PORTS-1:0] hit_sel;
   logic                 any_hit;
   logic [NUM_PORTS:0]   addr_sel;
   logic [NUM_PORTS:0]   data_sel;
   logic                 dft_accept;

   dft_state_t           dft_state;
   logic                 dft_ready;
   logic [1:0]           dft_resp;

   logic                 port_ready;
   logic [1:0]           port_resp;
   logic [DATA_W-1:0]    port_rdata;
   logic [USER_W-1:0]    port_ruser;

   // Region match, lowest index wins on overlap.
   always_comb begin
      hit     = '0;
      hit_sel = '0;
      any_hit = 1'b0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         hit[i] = ((decode_addr_dec & MASK[i*22 +: 22]) == (BASE[i*22 +: 22] & MASK[i*22 +: 22]));
         if (hit[i] && !any_hit) begin
            hit_sel[i] = 1'b1;
            any_hit    = 1'b1;
         end
      end
   end

   // An idle transfer to an unmapped address keeps the current path.
   always_comb begin
      if (any_hit)
         addr_sel = {1'b0, hit_sel};
      else if (trans_dec == 2'b00)
         addr_sel = data_sel;
      else
         addr_sel = SEL_DFT;
   end

   assign sel_out    = sel_dec ? addr_sel[NUM_PORTS-1:0] : '0;
   assign active_dec = (|(addr_sel[NUM_PORTS-1:0] & active_in)) | addr_sel[NUM_PORTS];
   assign dft_accept = sel_dec & HREADYS & addr_sel[NUM_PORTS] & trans_dec[1];

   always_ff @(posedge HCLK) begin
      if (HRESET)
         data_sel <= SEL_P0;
      else if (HREADYS)
         data_sel <= addr_sel;
   end

   // Two-cycle ERROR: low-ready first cycle, high-ready second cycle.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         dft_state   <= D_IDLE;
         dft_ready   <= 1'b1;
         dft_resp    <= RESP_OKAY;
         dft_err_cnt <= 8'd0;
      end else begin
         case (dft_state)
            D_IDLE, D_ERR2: begin
               if (dft_accept) begin
                  dft_state <= D_ERR1;
                  dft_ready <= 1'b0;
                  dft_resp  <= RESP_ERROR;
                  if (dft_err_cnt != 8'hFF)
                     dft_err_cnt <= dft_err_cnt + 8'd1;
               end else begin
                  dft_state <= D_IDLE;
                  dft_ready <= 1'b1;
                  dft_resp  <= RESP_OKAY;
               end
            end
            D_ERR1: begin
               dft_state <= D_ERR2;
               dft_ready <= 1'b1;
               dft_resp  <= RESP_ERROR;
            end
            default: begin
               dft_state <= D_IDLE;
               dft_ready <= 1'b1;
               dft_resp  <= RESP_OKAY;
            end
         endcase
      end
   end

   // data_sel is one-hot, so an AND-OR mux is sufficient.
   always_comb begin
      port_ready = 1'b0;
      port_resp  = '0;
      port_rdata = '0;
      port_ruser = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         port_ready = port_ready | (data_sel[i] & readyout_in[i]);
         port_resp  = port_resp  | ({2{data_sel[i]}} & resp_in[i*2 +: 2]);
         port_rdata = port_rdata | ({DATA_W{data_sel[i]}} & rdata_in[i*DATA_W +: DATA_W]);
         port_ruser = port_ruser | ({USER_W{data_sel[i]}} & ruser_in[i*USER_W +: USER_W]);
      end
   end

   assign HREADYOUTS = data_sel[NUM_PORTS] ? dft_ready : port_ready;
   assign HRESPS     = data_sel[NUM_PORTS] ? dft_resp  : port_resp;
   assign HRDATAS    = data_sel[NUM_PORTS] ? '0 : port_rdata;
   assign HRUSERS    = data_sel[NUM_PORTS] ? '0 : port_ruser;

endmodule

// File: doc/ahb_param_decoder.md
Name: ahb_param_decoder

Overview:
- Parametrised per-input-port decoder for the AHB bus matrix, one instance per input stage.
- Maps each address-phase transfer to one of NUM_PORTS output stages using per-port base/mask regions. Unmapped transfers go to a built-in default slave that gives a two-cycle ERROR response.
- Tracks the data-phase owner, muxes HREADYOUT/HRESP/HRDATA/HRUSER back to the input stage, and counts default-slave errors.

Parameters:
- NUM_PORTS, 4, number of output stages (1..8).
- DATA_W, 32, HRDATA width.
- USER_W, 32, HRUSER width.
- BASE, {22'h180000,22'h100000,22'h080000,22'h000000}, flattened NUM_PORTS*22 region bases, compared against address bits [31:10]. Port 0 occupies the least significant slice.
- MASK, {22'h3FFFFF,22'h3C0000,22'h3FFFC0,22'h3FFFC0}, flattened NUM_PORTS*22 compare masks, also over address bits [31:10].
- Default region map: port0 0x00000000-0x0000FFFF; port1 0x20000000-0x2000FFFF; port2 0x40000000-0x4FFFFFFF; port3 0x60000000-0x600003FF.

Ports:
- HCLK  in  1  AHB clock
- HRESET  in  1  reset, synchronous, active-high
- HREADYS  in  1  input-stage HREADY (transfer done)
- sel_dec  in  1  input-stage HSEL
- decode_addr_dec  in  22  HADDR[31:10]
- trans_dec  in  2  HTRANS
- active_in  in  NUM_PORTS  per-output-stage active flags
- readyout_in  in  NUM_PORTS  per-port HREADYOUT
- resp_in  in  2*NUM_PORTS  per-port HRESP, flattened
- rdata_in  in  DATA_W*NUM_PORTS  per-port HRDATA, flattened
- ruser_in  in  USER_W*NUM_PORTS  per-port HRUSER, flattened
- sel_out  out  NUM_PORTS  one-hot output-stage select
- active_dec  out  1  active flag of the address-phase target
- HREADYOUTS  out  1  muxed HREADYOUT
- HRESPS  out  2  muxed HRESP
- HRDATAS  out  DATA_W  muxed HRDATA
- HRUSERS  out  USER_W  muxed HRUSER
- dft_err_cnt  out  8  saturating count of default-slave ERROR responses

Behaviour:
- Hit rule: hit[i] = ((decode_addr_dec & MASK_i) == (BASE_i & MASK_i)). When several ports hit, the lowest index wins.
- Address target addr_sel (NUM_PORTS+1 bits, one-hot; bit NUM_PORTS is the default slave):
  - If any port hits, addr_sel = the winning port.
  - Else if trans_dec==IDLE (2'b00), addr_sel = data_sel. An idle, unmapped address never switches the path.
  - Else addr_sel = default slave.
- sel_out = addr_sel[NUM_PORTS-1:0] gated by sel_dec. It is combinational and all zero when sel_dec=0.
- active_dec = active_in of the addressed port, or 1 when the default slave is addressed.
- Data-phase owner data_sel:
  - Register; reset value is port 0.
  - Loads addr_sel on a rising HCLK edge when HREADYS=1, otherwise holds.
- Data-phase outputs follow data_sel combinationally (HREADYOUTS, HRESPS, HRDATAS, HRUSERS).
- When the default slave owns the data phase, HRDATAS=0 and HRUSERS=0.
- Default-slave FSM:
  - States: D_IDLE, D_ERR1, D_ERR2.
  - D_IDLE: outputs ready=1, resp=OKAY. Goes to D_ERR1 when sel_dec & HREADYS & default selected & trans_dec[1]=1 (NONSEQ/SEQ).
  - D_ERR1: ready=0, resp=ERROR (2'b01). Always goes to D_ERR2.
  - D_ERR2: ready=1, resp=ERROR. Goes to D_ERR1 if another qualifying default transfer is accepted in this cycle, else to D_IDLE.
  - IDLE/BUSY transfers to the default slave get a zero-wait OKAY.
- dft_err_cnt:
  - Increments on each entry to D_ERR1.
  - Saturates at 8'hFF.
  - Cleared only by reset.
- Reset (HRESET=1 at a clock edge, any state, including mid-ERROR):
  - data_sel=port 0, FSM=D_IDLE, dft_err_cnt=0.
  - Outputs next cycle: HREADYOUTS=readyout_in[0], HRESPS=resp_in[1:0].
- Simultaneous events: a new address phase is sampled in the same cycle the previous data phase completes. data_sel and the FSM update on the same edge.

Test Plan:
- Read 0x00001000, then 0x40000004, HREADYS=1 throughout -> sel_out=4'b0001, then 4'b0100. HRDATAS returns rdata_in port0 then port2, one cycle after each address phase.
- NONSEQ to 0x10000000 (unmapped) -> sel_out=0. Data phase: HREADYOUTS=0,HRESPS=01, then HREADYOUTS=1,HRESPS=01. HRDATAS=0. dft_err_cnt=1.
- Back-to-back NONSEQ to unmapped addresses, with the second accepted in D_ERR2 -> the ERR1/ERR2 sequence repeats without passing through D_IDLE. dft_err_cnt=2.
- After a port1 access, IDLE with HADDR=0x10000000 -> data_sel stays port1. HREADYOUTS tracks readyout_in[1]. No error response.
- Port2 holds readyout_in[2]=0 for 3 cycles -> HREADYOUTS=0 for 3 cycles. data_sel does not change even though a new address is presented.
- Assert HRESET during D_ERR1 -> the next cycle shows FSM=D_IDLE, data_sel=port0, dft_err_cnt=0. Also: 300 unmapped NONSEQ transfers -> dft_err_cnt=8'hFF.
